// File: rtl/mem_responder.sv
// mem_responder: word-addressed 16-bit memory target for the multicycle
// datapath. Each access is accepted in IDLE, held for WAIT_CYCLES wait
// states, then completed with a one-cycle ready pulse.
//
// Optional feature macro: ADR_CHECK_EN
//   defined   : accesses with any adr[15:AW] bit set raise err with ready,
//               writes are dropped and reads return 16'hDEAD.
//   undefined : err is tied 0 and addresses alias modulo 2**AW.
//
// Handshake: req (with we/adr/writedata) is sampled only while the FSM is
// in IDLE; a sampled req is an accepted access and busy rises on that edge.
// Inputs are ignored while busy=1. Completion is a single-cycle ready pulse
// with readdata/err valid in that cycle; busy falls when ready falls. A req
// still high in the first IDLE cycle after ready is a new access.

module mem_responder #(
   parameter int AW          = 8,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        we,
   input  logic [15:0] adr,
   input  logic [15:0] writedata,
   output logic [15:0] readdata,
   output logic        ready,
   output logic        busy,
   output logic        err,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   localparam bit         NO_WAIT  = (WAIT_CYCLES == 0);
   localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
   localparam int         DEPTH    = 2 ** AW;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        we_q, we_d;
   logic [15:0] adr_q, adr_d;
   logic [15:0] wd_q, wd_d;
   logic [15:0] readdata_q, readdata_d;

   logic [15:0] mem_q [DEPTH];

   // Access attributes as seen on the commit edge. With no wait states the
   // commit happens on the accepting edge itself, so the live inputs are
   // used while still in IDLE; otherwise the latched copies are used.
   logic        acc_we;
   logic [15:0] acc_adr;
   logic [15:0] acc_wd;
   logic        acc_oor;
   logic        commit;
   logic        mem_we;

   assign acc_we  = (state_q == S_IDLE) ? we        : we_q;
   assign acc_adr = (state_q == S_IDLE) ? adr       : adr_q;
   assign acc_wd  = (state_q == S_IDLE) ? writedata : wd_q;

`ifdef ADR_CHECK_EN
   logic err_q, err_d;
   assign acc_oor = |acc_adr[15:AW];
   assign err     = err_q;
`else
   logic unused_adr_hi;
   assign acc_oor       = 1'b0;
   assign unused_adr_hi = ^acc_adr[15:AW];
   assign err           = 1'b0;
`endif

   // The commit edge is the one that moves the FSM into RESP.
   assign commit = (state_d == S_RESP) && (state_q != S_RESP);
   // Reset is asynchronous, so an edge that arrives while reset is held
   // must never store an aborted write.
   assign mem_we = commit && acc_we && !acc_oor && !reset;

   // Next-state, counter and request-latch logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      adr_d   = adr_q;
      wd_d    = wd_q;
      unique case (state_q)
         S_IDLE: begin
            if (req) begin
               we_d  = we;
               adr_d = adr;
               wd_d  = writedata;
               if (NO_WAIT) begin
                  state_d = S_RESP;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = CNT_INIT;
               end
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Read data is loaded only by a completing read and held otherwise.
   always_comb begin
      readdata_d = readdata_q;
      if (commit && !acc_we) begin
         readdata_d = acc_oor ? 16'hDEAD : mem_q[acc_adr[AW-1:0]];
      end
   end

`ifdef ADR_CHECK_EN
   // err is raised for exactly the RESP cycle of an out-of-range access.
   always_comb begin
      err_d = commit && acc_oor;
   end
`endif

   // State, counter, latched request and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= 4'd0;
         we_q       <= 1'b0;
         adr_q      <= 16'd0;
         wd_q       <= 16'd0;
         readdata_q <= 16'd0;
`ifdef ADR_CHECK_EN
         err_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         we_q       <= we_d;
         adr_q      <= adr_d;
         wd_q       <= wd_d;
         readdata_q <= readdata_d;
`ifdef ADR_CHECK_EN
         err_q      <= err_d;
`endif
      end
   end

   // Storage array; contents survive reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[acc_adr[AW-1:0]] <= acc_wd;
      end
   end

   assign readdata  = readdata_q;
   assign ready     = (state_q == S_RESP);
   assign busy      = (state_q != S_IDLE);
   assign dbg_state = state_q;

endmodule
